btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_pkg.sv | 22 ++
 rtl/debounce_bit.sv | 111 +++++++++++
 rtl/btn_conditioner.sv | 35 +++
 tb/tb_btn_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: channel count, default
// debounce length and the per-bit debounce FSM state encoding.
package btn_conditioner_pkg;

  localparam int NUM_BTNS            = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF           = 16;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t STABLE_LO = 2'd0;
  localparam fsm_state_t WAIT_HI   = 2'd1;
  localparam fsm_state_t STABLE_HI = 2'd2;
  localparam fsm_state_t WAIT_LO   = 2'd3;

  // The debounced level is high for the whole time the button counts as pressed,
  // including while a release is still being qualified.
  function automatic logic level_of(input fsm_state_t s);
    return (s == STABLE_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with stability
// counter, registered press pulse and a sticky press latch with clear.
module debounce_bit
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       latch_o,
  output fsm_state_t state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       sync_q;
  logic             sync_bit;
  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             latch_q, latch_d;

  assign sync_bit = sync_q[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= CNT_ZERO;
      pulse_q <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      latch_q <= latch_d;
    end
  end

  // The count only runs in the WAIT states and is cleared at the hand-over to
  // the new STABLE state, so it tops out at CNT_LAST and can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (sync_bit) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!sync_bit) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_bit) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (sync_bit) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // The pulse is registered on the same edge that enters STABLE_HI, so it
  // lines up with the first cycle the debounced level reads 1. The latch is
  // set from the registered pulse, which lets a coinciding clear lose.
  always_comb begin
    pulse_d = (state_q == WAIT_HI) && (state_d == STABLE_HI);
    latch_d = pulse_q | (latch_q & ~clr_i);
    level_o = level_of(state_q);
    pulse_o = pulse_q;
    latch_o = latch_q;
    state_o = state_q;
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four-channel pushbutton conditioner: each raw button level is synchronized,
// debounced, and turned into a level, a press pulse and a sticky press flag.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BTNS-1:0]   raw_buttons,
  input  logic [NUM_BTNS-1:0]   clr,
  output logic [NUM_BTNS-1:0]   pushbuttons,
  output logic [NUM_BTNS-1:0]   press_pulse,
  output logic [NUM_BTNS-1:0]   press_latch,
  output logic [2*NUM_BTNS-1:0] dbg_state
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_bit (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_buttons[i]),
      .clr_i   (clr[i]),
      .level_o (pushbuttons[i]),
      .pulse_o (press_pulse[i]),
      .latch_o (press_latch[i]),
      .state_o (dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// checked cycle by cycle against a sliding-window reference model.
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_buttons = 4'b0;
  logic [3:0] clr = 4'b0;
  logic [3:0] pushbuttons, press_pulse, press_latch;
  logic [7:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];

  // Reference model state: recent raw samples, recent synchronized samples,
  // and the expected outputs after the latest edge.
  logic [3:0] raw_hist[$];
  logic [3:0] syn_hist[$];
  logic [3:0] m_pb = 4'b0, m_pulse = 4'b0, m_latch = 4'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  btn_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_buttons (raw_buttons),
    .clr         (clr),
    .pushbuttons (pushbuttons),
    .press_pulse (press_pulse),
    .press_latch (press_latch),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk(name, {4'b0, act}, {4'b0, exp});
  endtask

  // ---------------- reference model ----------------
  // A button's debounced level flips when the last DB synchronized samples all
  // disagree with it; synchronized samples are the raw levels two edges back.
  task automatic model_step(input logic [3:0] raw, input logic [3:0] clr_v, input logic rst);
    logic [3:0] s;
    logic [3:0] nxt_pb;
    logic       all_flip;
    if (rst) begin
      raw_hist.delete();
      syn_hist.delete();
      m_pb    = 4'b0;
      m_pulse = 4'b0;
      m_latch = 4'b0;
    end else begin
      s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 4'b0;
      raw_hist.push_back(raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      syn_hist.push_back(s);
      if (syn_hist.size() > DB) void'(syn_hist.pop_front());
      m_latch = m_pulse | (m_latch & ~clr_v);
      nxt_pb  = m_pb;
      for (int b = 0; b < 4; b++) begin
        if (syn_hist.size() == DB) begin
          all_flip = 1'b1;
          for (int j = 0; j < DB; j++)
            if (syn_hist[j][b] == m_pb[b]) all_flip = 1'b0;
          if (all_flip) nxt_pb[b] = ~m_pb[b];
        end
      end
      m_pulse = nxt_pb & ~m_pb;
      m_pb    = nxt_pb;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; the expected response to
  // the next edge is queued as that edge occurs.
  task automatic step(input logic [3:0] raw, input logic [3:0] clr_v, input logic rst);
    raw_buttons = raw;
    clr         = clr_v;
    reset       = rst;
    model_step(raw, clr_v, rst);
    @(posedge clock);
    exp_q.push_back({m_pb, m_pulse, m_latch});
    #1;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 4'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : monitor
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk4("mon_pushbuttons", pushbuttons, e[11:8]);
      chk4("mon_press_pulse", press_pulse, e[7:4]);
      chk4("mon_press_latch", press_latch, e[3:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r, c;
    logic       rs;

    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    chk4("reset_pushbuttons", pushbuttons, 4'b0000);
    chk4("reset_pulse", press_pulse, 4'b0000);
    chk4("reset_latch", press_latch, 4'b0000);
    chk("reset_fsm_state", dbg_state, {4{STABLE_LO}});

    // Single press on bit0: level appears on the 6th edge.
    hold(4'b0001, 5);
    chk4("press0_edge5_level", pushbuttons, 4'b0000);
    hold(4'b0001, 1);
    chk4("press0_edge6_level", pushbuttons, 4'b0001);
    chk4("press0_edge6_pulse", press_pulse, 4'b0001);
    hold(4'b0001, 1);
    chk4("press0_pulse_one_cycle", press_pulse, 4'b0000);
    chk4("press0_latch", press_latch, 4'b0001);
    hold(4'b0001, 3);

    // Release bit0: level drops on the 6th edge, no pulse, latch stays.
    hold(4'b0000, 5);
    chk4("release0_edge5_level", pushbuttons, 4'b0001);
    hold(4'b0000, 1);
    chk4("release0_edge6_level", pushbuttons, 4'b0000);
    chk4("release0_no_pulse", press_pulse, 4'b0000);
    chk4("release0_latch_kept", press_latch, 4'b0001);
    hold(4'b0000, 2);

    // Bouncing bit2: three stable samples then a drop never qualifies.
    for (int k = 0; k < 4; k++) begin
      hold(4'b0100, 3);
      hold(4'b0000, 1);
      chk4("bounce2_level", pushbuttons, 4'b0000);
      chk4("bounce2_pulse", press_pulse, 4'b0000);
    end
    hold(4'b0000, 4);

    // New press on bit0 with a clear in the pulse cycle: set wins.
    hold(4'b0001, 6);
    chk4("press0b_pulse", press_pulse, 4'b0001);
    step(4'b0001, 4'b0001, 1'b0);
    chk4("clr_vs_set_latch", press_latch, 4'b0001);
    step(4'b0001, 4'b0001, 1'b0);
    chk4("clr_latch", press_latch, 4'b0000);
    step(4'b0001, 4'b1111, 1'b0);
    chk4("clr_on_zero_latch", press_latch, 4'b0000);
    hold(4'b0000, 8);

    // Reset at count=2 while bit3 is held, then re-debounce after release.
    hold(4'b1000, 4);
    step(4'b1000, 4'b0000, 1'b1);
    chk4("mid_reset_level", pushbuttons, 4'b0000);
    chk4("mid_reset_pulse", press_pulse, 4'b0000);
    chk4("mid_reset_latch", press_latch, 4'b0000);
    hold(4'b1000, 5);
    chk4("post_reset_edge5_level", pushbuttons, 4'b0000);
    hold(4'b1000, 1);
    chk4("post_reset_edge6_level", pushbuttons, 4'b1000);
    chk4("post_reset_edge6_pulse", press_pulse, 4'b1000);
    hold(4'b0000, 8);

    // All four bits rise together.
    hold(4'b1111, 5);
    chk4("all_edge5_level", pushbuttons, 4'b1000 & 4'b0000);
    hold(4'b1111, 1);
    chk4("all_edge6_level", pushbuttons, 4'b1111);
    chk4("all_edge6_pulse", press_pulse, 4'b1111);
    hold(4'b1111, 1);
    chk4("all_latch", press_latch, 4'b1111);

    // Randomized bouncing, clears and occasional resets.
    r = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      c  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rs = ($urandom_range(0, 249) == 0);
      step(r, c, rs);
    end

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
